serdes_align_ctrl: RTL and testbench
====================================

Name: serdes_align_ctrl

Overview:
Word-alignment and link-lock controller placed directly after the 8-bit deserializer.
- Watches parallel words from the deserializer during link training.
- Pulses bitslip to rotate the deserializer's word boundary until the training SYNC word is seen consistently.
- Once locked, forwards payload words and strips the periodic SYNC words.
- Monitors SYNC-word recurrence and drops lock, with hysteresis, when the stream misaligns.

Parameters:
SYNC_WORD, 8'hBC, training/framing pattern
LOCK_COUNT, 4, consecutive SYNC words needed in VERIFY to declare lock (>=1)
UNLOCK_COUNT, 3, consecutive missed frame SYNCs in LOCKED that drop lock (>=1)
MAX_SLIPS, 8, slips in one hunt before declaring failure
SLIP_SETTLE, 2, valid words discarded after each bitslip
FRAME_LEN, 16, words per frame in LOCKED, SYNC at position 0 (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  enable; low forces IDLE
rx_word  in  8  parallel word from deserializer
rx_valid  in  1  rx_word valid this cycle
bitslip  out  1  one-cycle pulse: deserializer shifts word boundary by one bit
locked  out  1  link aligned
align_fail  out  1  hunt exhausted MAX_SLIPS; sticky until en low
word_out  out  8  payload word (registered)
word_valid  out  1  word_out valid
err_count  out  8  saturating count of missed frame SYNCs while LOCKED
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: bitslip, locked, align_fail, word_out, word_valid, err_count, state_dbg. All internal counters 0.
- Only cycles with rx_valid=1 are evaluated; idle cycles hold all counters.
- en=0 in any state: next state IDLE, all counters cleared except err_count, bitslip=0. en has priority over a simultaneous rx_valid.
- IDLE: locked=0. en=1 -> HUNT with slip_cnt=0.
- HUNT, valid word:
  - word==SYNC_WORD -> VERIFY, match_cnt=1.
  - else if slip_cnt==MAX_SLIPS -> FAIL.
  - else bitslip=1 for exactly one cycle, slip_cnt++, -> SETTLE.
- SETTLE: discard SLIP_SETTLE valid words, then -> HUNT. No bitslip is issued in SETTLE.
- VERIFY, valid word:
  - SYNC with match_cnt+1==LOCK_COUNT -> LOCKED, frame_pos=1, miss_cnt=0, slip_cnt=0.
  - SYNC otherwise: match_cnt++.
  - non-SYNC: identical to the HUNT mismatch path (slip or FAIL).
- LOCKED: locked=1.
  - Every valid word advances frame_pos, wrapping FRAME_LEN-1 -> 0.
  - Position 0: SYNC resets miss_cnt; non-SYNC increments miss_cnt and err_count (err_count saturates at 255). The position-0 word is never forwarded.
  - Positions 1..FRAME_LEN-1: word_out<=rx_word and word_valid=1 on the next cycle (latency 1), including words equal to SYNC_WORD.
  - miss_cnt reaching UNLOCK_COUNT -> HUNT. locked falls the same cycle as the transition register update. slip_cnt=0. No slip on the transition.
- FAIL: align_fail=1, locked=0, no bitslip. Stays until en=0.
- word_valid is 0 in every state except LOCKED.
- bitslip never asserts on two consecutive cycles.
- state_dbg encoding: IDLE=0, HUNT=1, SETTLE=2, VERIFY=3, LOCKED=4, FAIL=5.
- err_count clears only on rst.

Decomposition:
- Package serdes_pkg holds:
  - the state enum and its encodings;
  - the default SYNC_WORD constant;
  - a shared word-width constant of 8, used by the serializer/deserializer as well.
- One sub-module, serdes_lock_monitor, owns frame_pos, miss_cnt, err_count and the unlock decision. Its interface:
  - inputs: rx_valid, is_sync, active;
  - outputs: at_sync_pos, unlock, err_count.
- Top holds the FSM, slip/settle/match counters and the output register.

Test Plan:
- Aligned SYNC stream (8'hBC every valid cycle), en=1 -> no bitslip; locked=1 after 4th SYNC; state_dbg 1->3->4.
- Stream rotated by 3 bits (8'h97 repeating) -> exactly 3 bitslip pulses, each followed by 2 discarded words; deserializer model realigns; locked=1 after 4 SYNCs.
- Random non-SYNC data forever -> 8 bitslip pulses then align_fail=1, state 5. Drop en for one cycle -> align_fail=0, state 0, then HUNT resumes.
- Locked, frames of SYNC + 15 payload words 8'h01..8'h0F -> word_valid high 15 of every 16 valid cycles; word_out 8'h01..8'h0F one cycle after input; SYNC never forwarded.
- Locked, corrupt position-0 word in 2 consecutive frames, then valid SYNC -> err_count=2, locked stays 1. Corrupt 3 consecutive -> err_count=5, locked=0, state 1.
- Assert rst mid-VERIFY and again mid-LOCKED with rx_valid active -> all outputs 0 immediately (asynchronously); en=1 after release restarts HUNT cleanly.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES receive path: word width, default framing
// pattern and the alignment controller state encoding.
package serdes_pkg;

  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 8'hBC;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/serdes_align_ctrl_if.sv
// Deserializer-side word stream and alignment status bundle.
interface serdes_align_ctrl_if;
  import serdes_pkg::*;

  logic              en;
  logic [WORD_W-1:0] rx_word;
  logic              rx_valid;
  logic              bitslip;
  logic              locked;
  logic              align_fail;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic [7:0]        err_count;
  logic [2:0]        state_dbg;

  modport master (
    output en, rx_word, rx_valid,
    input  bitslip, locked, align_fail, word_out, word_valid, err_count, state_dbg
  );

  modport slave (
    input  en, rx_word, rx_valid,
    output bitslip, locked, align_fail, word_out, word_valid, err_count, state_dbg
  );
endinterface

// File: rtl/serdes_lock_monitor.sv
// Tracks frame position while locked, counts missed frame SYNCs and decides
// when lock must be dropped.
module serdes_lock_monitor
  import serdes_pkg::*;
#(
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned FRAME_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic       is_sync,
  input  logic       active,
  output logic       at_sync_pos,
  output logic       unlock,
  output logic [7:0] err_count
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);

  logic [PW-1:0] frame_pos_r;
  logic [MW-1:0] miss_cnt_r;
  logic [7:0]    err_count_r;
  logic          miss_s;

  assign at_sync_pos = (frame_pos_r == PW'(1'b0));
  assign miss_s      = active & rx_valid & at_sync_pos & ~is_sync;
  assign unlock      = miss_s & ((32'(miss_cnt_r) + 32'd1) >= UNLOCK_COUNT);
  assign err_count   = err_count_r;

  // Position is preloaded to 1 while idle: the SYNC that completes lock is slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_pos_r <= PW'(1'b0);
      miss_cnt_r  <= MW'(1'b0);
      err_count_r <= 8'd0;
    end else if (!active) begin
      frame_pos_r <= PW'(1'b1);
      miss_cnt_r  <= MW'(1'b0);
    end else if (rx_valid) begin
      frame_pos_r <= (32'(frame_pos_r) == FRAME_LEN - 32'd1) ? PW'(1'b0)
                                                              : frame_pos_r + PW'(1'b1);
      if (at_sync_pos) begin
        if (is_sync) begin
          miss_cnt_r <= MW'(1'b0);
        end else begin
          miss_cnt_r  <= miss_cnt_r + MW'(1'b1);
          err_count_r <= sat_inc8(err_count_r);
        end
      end
    end
  end
endmodule

// File: rtl/serdes_align_ctrl.sv
// Word-alignment and link-lock controller: hunts for SYNC with bitslip pulses,
// verifies lock, then forwards payload and strips framing SYNC words.
module serdes_align_ctrl
  import serdes_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int unsigned       LOCK_COUNT   = 4,
  parameter int unsigned       UNLOCK_COUNT = 3,
  parameter int unsigned       MAX_SLIPS    = 8,
  parameter int unsigned       SLIP_SETTLE  = 2,
  parameter int unsigned       FRAME_LEN    = 16
) (
  input  logic clk,
  input  logic rst,
  serdes_align_ctrl_if.slave bus
);
  localparam int SW = $clog2(MAX_SLIPS + 1);
  localparam int TW = (SLIP_SETTLE > 0) ? $clog2(SLIP_SETTLE + 1) : 1;
  localparam int CW = $clog2(LOCK_COUNT + 1);

  align_state_t      state_r, state_nxt;
  logic [SW-1:0]     slip_cnt_r, slip_cnt_nxt;
  logic [TW-1:0]     settle_cnt_r, settle_cnt_nxt;
  logic [CW-1:0]     match_cnt_r, match_cnt_nxt;
  logic              slip_s, fwd_s, is_sync_s, at_sync_pos_s, unlock_s;
  logic              bitslip_r, locked_r, align_fail_r, word_valid_r;
  logic [WORD_W-1:0] word_out_r;
  logic [7:0]        err_count_s;

  assign is_sync_s = (bus.rx_word == SYNC_WORD);

  serdes_lock_monitor #(
    .UNLOCK_COUNT (UNLOCK_COUNT),
    .FRAME_LEN    (FRAME_LEN)
  ) u_lock_monitor (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (bus.rx_valid),
    .is_sync     (is_sync_s),
    .active      (bus.en & (state_r == ST_LOCKED)),
    .at_sync_pos (at_sync_pos_s),
    .unlock      (unlock_s),
    .err_count   (err_count_s)
  );

  // State and hunt/settle/verify counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      slip_cnt_r   <= SW'(1'b0);
      settle_cnt_r <= TW'(1'b0);
      match_cnt_r  <= CW'(1'b0);
    end else begin
      state_r      <= state_nxt;
      slip_cnt_r   <= slip_cnt_nxt;
      settle_cnt_r <= settle_cnt_nxt;
      match_cnt_r  <= match_cnt_nxt;
    end
  end

  // Next state, counter updates, slip request and payload forward decision.
  always_comb begin
    state_nxt      = state_r;
    slip_cnt_nxt   = slip_cnt_r;
    settle_cnt_nxt = settle_cnt_r;
    match_cnt_nxt  = match_cnt_r;
    slip_s         = 1'b0;
    fwd_s          = 1'b0;
    if (!bus.en) begin
      state_nxt      = ST_IDLE;
      slip_cnt_nxt   = SW'(1'b0);
      settle_cnt_nxt = TW'(1'b0);
      match_cnt_nxt  = CW'(1'b0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt    = ST_HUNT;
          slip_cnt_nxt = SW'(1'b0);
        end
        ST_HUNT, ST_VERIFY: begin
          if (!bus.rx_valid) begin
            state_nxt = state_r;
          end else if (is_sync_s && (state_r == ST_HUNT)) begin
            state_nxt     = ST_VERIFY;
            match_cnt_nxt = CW'(1'b1);
          end else if (is_sync_s) begin
            if ((32'(match_cnt_r) + 32'd1) >= LOCK_COUNT) begin
              state_nxt     = ST_LOCKED;
              slip_cnt_nxt  = SW'(1'b0);
              match_cnt_nxt = CW'(1'b0);
            end else begin
              match_cnt_nxt = match_cnt_r + CW'(1'b1);
            end
          end else if (32'(slip_cnt_r) == MAX_SLIPS) begin
            state_nxt     = ST_FAIL;
            match_cnt_nxt = CW'(1'b0);
          end else begin
            state_nxt      = ST_SETTLE;
            slip_s         = 1'b1;
            slip_cnt_nxt   = slip_cnt_r + SW'(1'b1);
            settle_cnt_nxt = TW'(1'b0);
            match_cnt_nxt  = CW'(1'b0);
          end
        end
        ST_SETTLE: begin
          if (!bus.rx_valid) begin
            state_nxt = ST_SETTLE;
          end else if ((32'(settle_cnt_r) + 32'd1) >= SLIP_SETTLE) begin
            state_nxt      = ST_HUNT;
            settle_cnt_nxt = TW'(1'b0);
          end else begin
            settle_cnt_nxt = settle_cnt_r + TW'(1'b1);
          end
        end
        ST_LOCKED: begin
          if (unlock_s) begin
            state_nxt    = ST_HUNT;
            slip_cnt_nxt = SW'(1'b0);
          end else begin
            fwd_s = bus.rx_valid & ~at_sync_pos_s;
          end
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags track the next state so they change with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitslip_r    <= 1'b0;
      locked_r     <= 1'b0;
      align_fail_r <= 1'b0;
      word_valid_r <= 1'b0;
      word_out_r   <= {WORD_W{1'b0}};
    end else begin
      bitslip_r    <= slip_s;
      locked_r     <= (state_nxt == ST_LOCKED);
      align_fail_r <= (state_nxt == ST_FAIL);
      word_valid_r <= fwd_s;
      if (fwd_s) begin
        word_out_r <= bus.rx_word;
      end
    end
  end

  assign bus.bitslip    = bitslip_r;
  assign bus.locked     = locked_r;
  assign bus.align_fail = align_fail_r;
  assign bus.word_valid = word_valid_r;
  assign bus.word_out   = word_out_r;
  assign bus.err_count  = err_count_s;
  assign bus.state_dbg  = state_r;
endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Randomized bench for serdes_align_ctrl: a rotating-deserializer stimulus
// model plus a rule-level reference model compared on every clock.
module tb_serdes_align_ctrl;
  import serdes_pkg::*;

  localparam logic [7:0] SYNC = 8'hBC;
  localparam int LOCK = 4, UNLOCK = 3, MAXS = 8, SETTLE = 2, FRAME = 16;
  localparam int M_IDLE = 0, M_HUNT = 1, M_SETTLE = 2, M_VERIFY = 3, M_LOCKED = 4, M_FAIL = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serdes_align_ctrl_if bus_if ();
  serdes_align_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  int vectors = 0;
  int miscompares = 0;
  int m_mode, m_slips, m_settle_left, m_matches, m_pos, m_misses, m_errs;
  bit exp_bitslip, exp_wv;
  logic [7:0] exp_wo;
  int rot, slip_seen, wv_seen;

  function automatic logic [7:0] rol8(input logic [7:0] w, input int r);
    logic [7:0] v = w;
    for (int i = 0; i < r; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_slips = 0; m_settle_left = 0; m_matches = 0;
    m_pos = 1; m_misses = 0; m_errs = 0;
    exp_bitslip = 1'b0; exp_wv = 1'b0; exp_wo = 8'h00;
  endtask

  task automatic model_step(input bit en, input bit rv, input logic [7:0] w);
    exp_bitslip = 1'b0;
    exp_wv      = 1'b0;
    if (!en) begin
      m_mode = M_IDLE; m_slips = 0; m_matches = 0; m_settle_left = 0; m_misses = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_HUNT; m_slips = 0;
    end else if (!rv || m_mode == M_FAIL) begin
      m_mode = m_mode;
    end else if (m_mode == M_SETTLE) begin
      m_settle_left--;
      if (m_settle_left == 0) m_mode = M_HUNT;
    end else if (m_mode == M_LOCKED) begin
      if (m_pos == 0) begin
        if (w == SYNC) m_misses = 0;
        else begin
          m_misses++;
          if (m_errs < 255) m_errs++;
        end
        if (m_misses == UNLOCK) begin m_mode = M_HUNT; m_slips = 0; end
      end else begin
        exp_wv = 1'b1; exp_wo = w;
      end
      m_pos = (m_pos + 1) % FRAME;
    end else if (w == SYNC) begin
      if (m_mode == M_HUNT) begin m_mode = M_VERIFY; m_matches = 1; end
      else begin
        m_matches++;
        if (m_matches == LOCK) begin m_mode = M_LOCKED; m_pos = 1; m_misses = 0; m_slips = 0; end
      end
    end else if (m_slips == MAXS) begin
      m_mode = M_FAIL;
    end else begin
      exp_bitslip = 1'b1; m_slips++; m_settle_left = SETTLE; m_mode = M_SETTLE;
    end
  endtask

  task automatic compare_all();
    chk("bitslip",    int'(bus_if.bitslip),    int'(exp_bitslip));
    chk("locked",     int'(bus_if.locked),     int'(m_mode == M_LOCKED));
    chk("align_fail", int'(bus_if.align_fail), int'(m_mode == M_FAIL));
    chk("word_valid", int'(bus_if.word_valid), int'(exp_wv));
    chk("word_out",   int'(bus_if.word_out),   int'(exp_wo));
    chk("err_count",  int'(bus_if.err_count),  m_errs);
    chk("state_dbg",  int'(bus_if.state_dbg),  m_mode);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bitslip"},    int'(bus_if.bitslip),    0);
    chk({tag, "_locked"},     int'(bus_if.locked),     0);
    chk({tag, "_align_fail"}, int'(bus_if.align_fail), 0);
    chk({tag, "_word_valid"}, int'(bus_if.word_valid), 0);
    chk({tag, "_word_out"},   int'(bus_if.word_out),   0);
    chk({tag, "_err_count"},  int'(bus_if.err_count),  0);
    chk({tag, "_state_dbg"},  int'(bus_if.state_dbg),  0);
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input bit en, input bit rv, input logic [7:0] w);
    bus_if.en = en; bus_if.rx_valid = rv; bus_if.rx_word = w;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(en, rv, w);
    #1;
    vectors++;
    compare_all();
    if (bus_if.bitslip) begin slip_seen++; rot = (rot + 1) % 8; end
    if (bus_if.word_valid) wv_seen++;
  endtask

  // One valid word through the deserializer model, optionally preceded by idle cycles.
  task automatic send(input logic [7:0] tx, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, rol8(tx, rot));
  endtask

  initial begin
    logic [7:0] w;
    bus_if.en = 1'b0; bus_if.rx_valid = 1'b0; bus_if.rx_word = 8'h00;
    rot = 0; slip_seen = 0; wv_seen = 0;
    model_reset();
    #2 rst = 1'b1;
    #1 chk_zero("reset_init");
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);

    // Aligned SYNC stream locks after four SYNCs with no slips.
    slip_seen = 0;
    step(1'b1, 1'b1, SYNC); chk("A_state_hunt", int'(bus_if.state_dbg), 1);
    step(1'b1, 1'b1, SYNC); chk("A_state_verify", int'(bus_if.state_dbg), 3);
    step(1'b1, 1'b1, SYNC);
    step(1'b1, 1'b1, SYNC); chk("A_not_yet_locked", int'(bus_if.locked), 0);
    step(1'b1, 1'b1, SYNC); chk("A_locked", int'(bus_if.locked), 1);
    chk("A_state_locked", int'(bus_if.state_dbg), 4);
    chk("A_no_slip", slip_seen, 0);

    // Stream rotated by 3 bits (8'h97) needs exactly three slips.
    step(1'b0, 1'b1, SYNC);
    rot = 5; slip_seen = 0;
    chk("B_first_word", int'(rol8(SYNC, rot)), 8'h97);
    repeat (30) send(SYNC, 1'b1);
    chk("B_slips", slip_seen, 3);
    chk("B_locked", int'(bus_if.locked), 1);
    chk("B_realigned", rot, 0);

    // Locked payload frames: SYNC stripped, 15 of 16 valid words forwarded.
    step(1'b0, 1'b0, 8'h00);
    rot = 0;
    step(1'b1, 1'b0, 8'h00);
    repeat (4) send(SYNC, 1'b0);
    wv_seen = 0;
    for (int f = 0; f < 3; f++) begin
      for (int p = 1; p < 16; p++) send(8'(p), 1'b1);
      send(SYNC, 1'b1);
    end
    chk("D_forwarded", wv_seen, 45);
    chk("D_last_payload", int'(bus_if.word_out), 8'h0F);
    chk("D_sync_not_fwd", int'(bus_if.word_valid), 0);

    // Two corrupted frame SYNCs keep lock; three in a row drop it.
    for (int f = 0; f < 3; f++) begin
      for (int p = 1; p < 16; p++) send(8'($urandom), 1'b1);
      send((f < 2) ? 8'h00 : SYNC, 1'b1);
    end
    chk("E_err_two", int'(bus_if.err_count), 2);
    chk("E_still_locked", int'(bus_if.locked), 1);
    for (int f = 0; f < 3; f++) begin
      for (int p = 1; p < 16; p++) send(8'($urandom), 1'b1);
      send(8'h3C, 1'b1);
    end
    chk("E_err_five", int'(bus_if.err_count), 5);
    chk("E_unlocked", int'(bus_if.locked), 0);
    chk("E_state_hunt", int'(bus_if.state_dbg), 1);

    // Never-aligning data exhausts the slip budget and fails.
    slip_seen = 0;
    repeat (40) begin
      w = 8'($urandom);
      if (w == SYNC) w = 8'h3C;
      repeat ($urandom_range(0, 1)) step(1'b1, 1'b0, 8'($urandom));
      step(1'b1, 1'b1, w);
    end
    chk("C_slips", slip_seen, 8);
    chk("C_align_fail", int'(bus_if.align_fail), 1);
    chk("C_state_fail", int'(bus_if.state_dbg), 5);
    step(1'b0, 1'b1, 8'h00);
    chk("C_fail_cleared", int'(bus_if.align_fail), 0);
    chk("C_state_idle", int'(bus_if.state_dbg), 0);
    step(1'b1, 1'b0, 8'h00);
    chk("C_hunt_again", int'(bus_if.state_dbg), 1);

    // Asynchronous reset mid-VERIFY, then mid-LOCKED.
    step(1'b0, 1'b0, 8'h00);
    rot = 0;
    step(1'b1, 1'b1, SYNC);
    step(1'b1, 1'b1, SYNC);
    step(1'b1, 1'b1, SYNC);
    chk("F_in_verify", int'(bus_if.state_dbg), 3);
    bus_if.rx_valid = 1'b1;
    #3 rst = 1'b1;
    #1 chk_zero("F_rst_verify");
    model_reset();
    step(1'b1, 1'b1, SYNC);
    rst = 1'b0;
    step(1'b1, 1'b1, SYNC);
    chk("F_restart_hunt", int'(bus_if.state_dbg), 1);
    repeat (4) send(SYNC, 1'b0);
    chk("F_relocked", int'(bus_if.locked), 1);
    repeat (5) send(8'($urandom), 1'b1);
    bus_if.rx_valid = 1'b1;
    #3 rst = 1'b1;
    #1 chk_zero("F_rst_locked");
    model_reset();
    step(1'b1, 1'b1, SYNC);
    rst = 1'b0;
    step(1'b1, 1'b1, SYNC);
    chk("F_restart_hunt2", int'(bus_if.state_dbg), 1);
    repeat (6) send(SYNC, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
